zorro_dma_arbiter: RTL and testbench

- Sequences 68000 three-wire bus arbitration (BR/BG/BGACK) between the accelerator CPU and up to four external DMA masters on the motherboard bus.
- Raises the CPU bus request and waits for the CPU grant and an idle bus.
- Grants one requester, chosen round-robin, and tracks its tenure via BGACK.
- Gates whether the CPU drives motherboard AS, replacing the ad-hoc grant/AS gating in the top level.

---
 rtl/zorro_dma_arbiter_if.sv | 26 ++
 rtl/zorro_dma_arbiter.sv | 138 +++++++++++++
 tb/tb_zorro_dma_arbiter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/zorro_dma_arbiter_if.sv
// zorro_dma_arbiter_if: 68000 three-wire arbitration signals between the arbiter and the bus side.
interface zorro_dma_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0] BR_n;
    logic               BGACK_n;
    logic               AS_CPU_n;
    logic               DTACK_n;
    logic               CPU_BG_n;
    logic               CPU_BR_n;
    logic [NUM_REQ-1:0] BG_n;
    logic               CPU_BUS_EN;
    logic [1:0]         OWNER;
    logic               DMA_ACTIVE;
    logic               TIMEOUT_ERR;

    modport master (
        output BR_n, BGACK_n, AS_CPU_n, DTACK_n, CPU_BG_n,
        input  CPU_BR_n, BG_n, CPU_BUS_EN, OWNER, DMA_ACTIVE, TIMEOUT_ERR
    );

    modport slave (
        input  BR_n, BGACK_n, AS_CPU_n, DTACK_n, CPU_BG_n,
        output CPU_BR_n, BG_n, CPU_BUS_EN, OWNER, DMA_ACTIVE, TIMEOUT_ERR
    );
endinterface

// File: rtl/zorro_dma_arbiter.sv
// zorro_dma_arbiter: BR/BG/BGACK sequencer granting the motherboard bus round-robin to external DMA masters.
module zorro_dma_arbiter #(
    parameter int NUM_REQ       = 2,
    parameter int GRANT_TIMEOUT = 16
) (
    input logic               C7M,
    input logic               RESET,
    zorro_dma_arbiter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, REQ, GRANT, OWNED, RELEASE, FOREIGN} state_t;

    state_t             state, state_n;
    logic [NUM_REQ-1:0] br1, brs, bg, bg_n;
    logic               bg1, bgs;
    logic [1:0]         last, last_n, owner, owner_n, pick;
    logic [7:0]         cnt, cnt_n;
    logic               cpu_br, cpu_br_n, en, en_n, act, act_n, terr, terr_n;
    logic [NUM_REQ-1:0] ob;
    int                 d, best;

    always_ff @(posedge C7M or posedge RESET)
        if (RESET) begin
            br1    <= '1;
            brs    <= '1;
            bg1    <= 1'b1;
            bgs    <= 1'b1;
            state  <= IDLE;
            last   <= 2'(NUM_REQ - 1);
            cnt    <= '0;
            cpu_br <= 1'b1;
            bg     <= '1;
            en     <= 1'b1;
            owner  <= '0;
            act    <= 1'b0;
            terr   <= 1'b0;
        end else begin
            br1    <= bus.BR_n;
            brs    <= br1;
            bg1    <= bus.BGACK_n;
            bgs    <= bg1;
            state  <= state_n;
            last   <= last_n;
            cnt    <= cnt_n;
            cpu_br <= cpu_br_n;
            bg     <= bg_n;
            en     <= en_n;
            owner  <= owner_n;
            act    <= act_n;
            terr   <= terr_n;
        end

    // Round-robin: smallest distance past the last grantee wins.
    always_comb begin
        pick = last;
        best = NUM_REQ;
        d    = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            d = (i - int'(last) - 1 + 2 * NUM_REQ) % NUM_REQ;
            if (!brs[i] && d < best) begin
                best = d;
                pick = 2'(i);
            end
        end
    end

    assign ob = brs >> owner;

    always_comb begin
        state_n  = state;
        last_n   = last;
        cnt_n    = cnt;
        cpu_br_n = cpu_br;
        bg_n     = bg;
        en_n     = en;
        owner_n  = owner;
        act_n    = act;
        terr_n   = 1'b0;
        case (state)
            IDLE:
                if (!bgs) begin
                    state_n = FOREIGN;
                    en_n    = 1'b0;
                    act_n   = 1'b1;
                end else if (!(&brs)) begin
                    state_n  = REQ;
                    cpu_br_n = 1'b0;
                end
            REQ:
                if (&brs) begin
                    state_n  = IDLE;
                    cpu_br_n = 1'b1;
                end else if (!bus.CPU_BG_n && bus.AS_CPU_n && bus.DTACK_n) begin
                    owner_n = pick;
                    bg_n    = ~(NUM_REQ'(1) << pick);
                    en_n    = 1'b0;
                    cnt_n   = '0;
                    state_n = GRANT;
                end
            // Acknowledge is checked first so it beats withdrawal and timeout.
            GRANT:
                if (!bgs) begin
                    state_n  = OWNED;
                    bg_n     = '1;
                    cpu_br_n = 1'b1;
                    act_n    = 1'b1;
                    last_n   = owner;
                end else if (ob[0]) begin
                    bg_n    = '1;
                    state_n = RELEASE;
                end else if (cnt == 8'(GRANT_TIMEOUT - 1)) begin
                    bg_n    = '1;
                    terr_n  = 1'b1;
                    last_n  = owner;
                    state_n = RELEASE;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            OWNED, FOREIGN:
                if (bgs) begin
                    act_n   = 1'b0;
                    state_n = RELEASE;
                end
            RELEASE: begin
                en_n     = 1'b1;
                cpu_br_n = &brs;
                state_n  = (&brs) ? IDLE : REQ;
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.CPU_BR_n    = cpu_br;
    assign bus.BG_n        = bg;
    assign bus.CPU_BUS_EN  = en;
    assign bus.OWNER       = owner;
    assign bus.DMA_ACTIVE  = act;
    assign bus.TIMEOUT_ERR = terr;
endmodule

// File: tb/tb_zorro_dma_arbiter.sv
// tb_zorro_dma_arbiter: vector table plus directed sequences for the DMA bus arbiter.
module tb_zorro_dma_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   passed = 0;
    int   total = 0;
    int   inv_bad = 0;

    zorro_dma_arbiter_if #(.NUM_REQ(2)) bus ();

    zorro_dma_arbiter #(.NUM_REQ(2), .GRANT_TIMEOUT(16)) dut (
        .C7M   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] br;
        logic       bgack;
        logic       as_n;
        logic       dtack;
        logic       cpu_bg;
        logic [7:0] exp;
    } vec_t;

    vec_t v[23];

    function automatic logic [7:0] outs();
        return {bus.CPU_BR_n, bus.BG_n, bus.CPU_BUS_EN, bus.OWNER, bus.DMA_ACTIVE, bus.TIMEOUT_ERR};
    endfunction

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", n, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        bus.BR_n     = 2'b11;
        bus.BGACK_n  = 1'b1;
        bus.AS_CPU_n = 1'b1;
        bus.DTACK_n  = 1'b1;
        bus.CPU_BG_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_bg(input logic [1:0] val, input string n);
        int c = 0;
        while (bus.BG_n !== val && c < 20) begin
            tick();
            c++;
        end
        chk(n, bus.BG_n, val);
    endtask

    task automatic wait_act(input logic val, input string n);
        int c = 0;
        while (bus.DMA_ACTIVE !== val && c < 12) begin
            tick();
            c++;
        end
        chk(n, bus.DMA_ACTIVE, val);
    endtask

    always @(negedge clk)
        if (!rst) begin
            if (bus.BG_n == 2'b00) inv_bad++;
            if (bus.BG_n != 2'b11 && bus.CPU_BUS_EN) inv_bad++;
        end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c, lo, bad;
        // expected = {CPU_BR_n, BG_n, CPU_BUS_EN, OWNER, DMA_ACTIVE, TIMEOUT_ERR}
        v[0]  = '{2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 8'b1_11_1_00_0_0};
        v[1]  = '{2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 8'b1_11_1_00_0_0};
        v[2]  = '{2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 8'b1_11_1_00_0_0};
        v[3]  = '{2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 8'b0_11_1_00_0_0};
        v[4]  = '{2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 8'b0_11_1_00_0_0};
        v[5]  = '{2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 8'b0_10_0_00_0_0};
        v[6]  = '{2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 8'b0_10_0_00_0_0};
        v[7]  = '{2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 8'b0_10_0_00_0_0};
        v[8]  = '{2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 8'b1_11_0_00_1_0};
        v[9]  = '{2'b11, 1'b0, 1'b1, 1'b1, 1'b1, 8'b1_11_0_00_1_0};
        v[10] = '{2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 8'b1_11_0_00_1_0};
        v[11] = '{2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 8'b1_11_0_00_1_0};
        v[12] = '{2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 8'b1_11_0_00_0_0};
        v[13] = '{2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 8'b1_11_1_00_0_0};
        v[14] = '{2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 8'b1_11_1_00_0_0};
        v[15] = '{2'b11, 1'b0, 1'b1, 1'b1, 1'b1, 8'b1_11_1_00_0_0};
        v[16] = '{2'b11, 1'b0, 1'b1, 1'b1, 1'b1, 8'b1_11_1_00_0_0};
        v[17] = '{2'b11, 1'b0, 1'b1, 1'b1, 1'b1, 8'b1_11_0_00_1_0};
        v[18] = '{2'b11, 1'b0, 1'b1, 1'b1, 1'b1, 8'b1_11_0_00_1_0};
        v[19] = '{2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 8'b1_11_0_00_1_0};
        v[20] = '{2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 8'b1_11_0_00_1_0};
        v[21] = '{2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 8'b1_11_0_00_0_0};
        v[22] = '{2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 8'b1_11_1_00_0_0};

        do_reset();
        chk("reset_state", outs(), 8'hF0);
        for (int i = 0; i < 23; i++) begin
            bus.BR_n     = v[i].br;
            bus.BGACK_n  = v[i].bgack;
            bus.AS_CPU_n = v[i].as_n;
            bus.DTACK_n  = v[i].dtack;
            bus.CPU_BG_n = v[i].cpu_bg;
            tick();
            chk($sformatf("vec[%0d]", i), outs(), v[i].exp);
        end

        // round robin over four tenures
        do_reset();
        bus.BR_n     = 2'b00;
        bus.CPU_BG_n = 1'b0;
        for (int t = 0; t < 4; t++) begin
            c = 0;
            while (bus.BG_n === 2'b11 && c < 20) begin
                tick();
                c++;
            end
            chk($sformatf("rr_owner[%0d]", t), bus.OWNER, t % 2);
            chk($sformatf("rr_bg[%0d]", t), bus.BG_n, (t % 2) ? 2'b01 : 2'b10);
            bus.BGACK_n = 1'b0;
            wait_act(1'b1, "rr_act_on");
            bus.BGACK_n = 1'b1;
            wait_act(1'b0, "rr_act_off");
        end

        // bus busy: AS then DTACK hold off the grant
        do_reset();
        bus.BR_n     = 2'b10;
        bus.CPU_BG_n = 1'b0;
        bus.AS_CPU_n = 1'b0;
        bad = 0;
        repeat (9) begin
            tick();
            if (bus.BG_n !== 2'b11) bad++;
        end
        chk("busy_cpu_br", bus.CPU_BR_n, 1'b0);
        bus.AS_CPU_n = 1'b1;
        bus.DTACK_n  = 1'b0;
        repeat (2) begin
            tick();
            if (bus.BG_n !== 2'b11) bad++;
        end
        chk("busy_no_grant", bad, 0);
        bus.DTACK_n = 1'b1;
        tick();
        chk("busy_grant", bus.BG_n, 2'b10);

        // grant timeout, failed master loses priority
        do_reset();
        bus.BR_n     = 2'b00;
        bus.CPU_BG_n = 1'b0;
        wait_bg(2'b10, "to_first_bg");
        lo = 0;
        while (bus.BG_n === 2'b10 && lo < 40) begin
            lo++;
            tick();
        end
        chk("to_len", lo, 16);
        chk("to_err", bus.TIMEOUT_ERR, 1'b1);
        tick();
        chk("to_err_pulse", bus.TIMEOUT_ERR, 1'b0);
        chk("to_bus_en", bus.CPU_BUS_EN, 1'b1);
        tick();
        chk("to_next_bg", bus.BG_n, 2'b01);
        chk("to_next_owner", bus.OWNER, 1);

        // withdrawal while requesting
        do_reset();
        bus.BR_n = 2'b10;
        repeat (3) tick();
        chk("wr_cpu_br_low", bus.CPU_BR_n, 1'b0);
        bus.BR_n = 2'b11;
        bad = 0;
        repeat (6) begin
            tick();
            if (bus.BG_n !== 2'b11) bad++;
        end
        bus.CPU_BG_n = 1'b0;
        repeat (4) begin
            tick();
            if (bus.BG_n !== 2'b11) bad++;
        end
        chk("wr_no_grant", bad, 0);
        chk("wr_cpu_br_high", bus.CPU_BR_n, 1'b1);

        // withdrawal while granted
        do_reset();
        bus.BR_n     = 2'b10;
        bus.CPU_BG_n = 1'b0;
        wait_bg(2'b10, "wg_grant");
        bus.BR_n = 2'b11;
        c = 0;
        while (bus.BG_n === 2'b10 && c < 10) begin
            tick();
            c++;
        end
        chk("wg_edges", c, 3);
        chk("wg_no_err", bus.TIMEOUT_ERR, 1'b0);
        tick();
        chk("wg_bus_en", bus.CPU_BUS_EN, 1'b1);
        chk("wg_cpu_br", bus.CPU_BR_n, 1'b1);

        // asynchronous reset during an owned tenure
        do_reset();
        bus.BR_n     = 2'b10;
        bus.CPU_BG_n = 1'b0;
        wait_bg(2'b10, "rst_grant");
        bus.BGACK_n = 1'b0;
        wait_act(1'b1, "rst_owned");
        #2 rst = 1'b1;
        #1;
        chk("rst_async", outs(), 8'hF0);
        do_reset();

        chk("invariants", inv_bad, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
